p5_writeback: RTL

Final pipeline stage of the SIMPLE processor. It retires stage-4 results back into the register file owned by the decode/register-read stage by driving `writeflag`/`writetarget`/`writeval`. It drains OUT instructions into a 4-entry output FIFO with a valid/ready port to the board display. It sequences halt so the core stops only after all OUT data has left.

---
 rtl/p5_pkg.sv | 13 +
 rtl/p5_out_fifo.sv | 69 ++++++
 rtl/p5_writeback.sv | 130 +++++++++++++
 3 files changed

// File: rtl/p5_pkg.sv
// Shared constants and state encoding for the SIMPLE processor writeback stage.
package p5_pkg;

    localparam logic [3:0] OP_OUT        = 4'd13;
    localparam int         OUT_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } p5_state_e;

endpackage

// File: rtl/p5_out_fifo.sv
// Output FIFO for OUT payloads; head is held in a register so the display port is glitch-free.
module p5_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_after_pop_s;
    logic [W-1:0]  head_q, head_d;
    logic          pop_s, push_s;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == {CW{1'b0}});
    assign count = cnt_q;
    assign head  = head_q;

    // Next pointers, occupancy and the value the head register must show next cycle.
    always_comb begin
        pop_s           = pop & ~empty;
        push_s          = push & (~full | pop_s);
        rd_d            = rd_q + AW'(pop_s);
        wr_d            = wr_q + AW'(push_s);
        cnt_after_pop_s = cnt_q - CW'(pop_s);
        cnt_d           = cnt_after_pop_s + CW'(push_s);
        if (cnt_d == {CW{1'b0}}) begin
            head_d = {W{1'b0}};
        end else if (cnt_after_pop_s == {CW{1'b0}}) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    // Storage, pointers and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            rd_q   <= {AW{1'b0}};
            wr_q   <= {AW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            head_q <= {W{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= push_data;
            end
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/p5_writeback.sv
// Writeback stage: register-file write port, OUT FIFO and halt sequencing.
// Optional retired-instruction counter enabled by defining P5_RETIRE_COUNT_EN.
module p5_writeback
    import p5_pkg::*;
#(
    parameter int OUT_DEPTH = OUT_DEPTH_DEF,
    parameter int W         = 16
) (
    input  logic          clockp5,
    input  logic          reset,
    input  logic          valid4,
    input  logic          writereg4,
    input  logic [2:0]    regaddress4,
    input  logic          readoutSelect4,
    input  logic [W-1:0]  aluresult4,
    input  logic [W-1:0]  readout4,
    input  logic [3:0]    opcode4,
    input  logic          haltin4,
    output logic          stall,
    output logic          writeflag,
    output logic [2:0]    writetarget,
    output logic [W-1:0]  writeval,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          halted,
    output logic [15:0]   retired_count
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    p5_state_e     state_q, state_d;
    logic          writeflag_q, writeflag_d;
    logic [2:0]    writetarget_q, writetarget_d;
    logic [W-1:0]  writeval_q, writeval_d;
    logic          is_out_s, pop_s, stall_s, accept_s, drained_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [W-1:0]  fifo_head_s;

    assign is_out_s  = (opcode4 == OP_OUT);
    assign pop_s     = ~fifo_empty_s & out_ready;
    // A full FIFO still takes an OUT when the display drains an entry in the same cycle.
    assign stall_s   = valid4 & ((state_q != RUN) | (is_out_s & fifo_full_s & ~pop_s));
    assign accept_s  = valid4 & ~stall_s;
    assign drained_s = fifo_empty_s | ((fifo_count_s == CW'(1)) & pop_s);

    p5_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clockp5),
        .rst_n     (reset),
        .push      (accept_s & is_out_s),
        .push_data (aluresult4),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Register-file write port; target and value hold when no write retires.
    always_comb begin
        writetarget_d = writetarget_q;
        writeval_d    = writeval_q;
        writeflag_d   = accept_s & writereg4 & ~is_out_s & ~haltin4;
        if (writeflag_d) begin
            writetarget_d = regaddress4;
            writeval_d    = readoutSelect4 ? readout4 : aluresult4;
        end else begin
            writetarget_d = writetarget_q;
            writeval_d    = writeval_q;
        end
    end

    // Halt sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept_s & haltin4) state_d = DRAIN;  else state_d = RUN;
            DRAIN:   if (drained_s)          state_d = HALTED; else state_d = DRAIN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State and write-port registers.
    always_ff @(posedge clockp5 or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            writeflag_q   <= 1'b0;
            writetarget_q <= 3'd0;
            writeval_q    <= {W{1'b0}};
        end else begin
            state_q       <= state_d;
            writeflag_q   <= writeflag_d;
            writetarget_q <= writetarget_d;
            writeval_q    <= writeval_d;
        end
    end

`ifdef P5_RETIRE_COUNT_EN
    logic [15:0] retired_q;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clockp5 or negedge reset) begin
        if (!reset) begin
            retired_q <= 16'd0;
        end else if (accept_s) begin
            retired_q <= retired_q + 16'd1;
        end else begin
            retired_q <= retired_q;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = 16'd0;
`endif

    assign stall       = stall_s;
    assign writeflag   = writeflag_q;
    assign writetarget = writetarget_q;
    assign writeval    = writeval_q;
    assign out_valid   = ~fifo_empty_s;
    assign out_data    = fifo_head_s;
    assign halted      = (state_q == HALTED);

endmodule
